// File: rtl/core_mem_responder.sv
// core_mem_responder: Harvard instruction/data RAMs plus an MMIO window
// (TX byte FIFO, cycle counter, halt and overflow flags) on the core bus.
module core_mem_responder #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [96:0] core_out,
  output logic [63:0] core_in,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt
);

  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [31:0] im_a;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic        dm_we;

  assign im_a  = core_out[31:0];
  assign dm_a  = core_out[63:32];
  assign dm_wd = core_out[95:64];
  assign dm_we = core_out[96];

  logic [FW-1:0] rd_ptr;
  logic [FW-1:0] wr_ptr;
  logic [FW:0]   count;
  logic          overflow;
  logic [31:0]   cycle_cnt;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          push_ok;

  logic [31:0]   mm_off;
  logic          mm_hit;
  logic [1:0]    mm_sel;
  logic          im_in;
  logic          dm_in;
  logic          pg_in;

  logic          wr_fifo;
  logic          wr_cnt;
  logic          wr_halt;
  logic          wr_ovc;
  logic          wr_dm;

  logic [31:0]   im_rd;
  logic [31:0]   dm_rd;
  logic [31:0]   mm_rd;

  // Window test by offset so a base near the top of memory cannot overflow.
  assign mm_off = dm_a - MMIO_BASE;
  assign mm_hit = mm_off < 32'd16;
  assign mm_sel = mm_off[3:2];

  assign im_in = im_a[31:2] < 30'(IMEM_WORDS);
  assign dm_in = !mm_hit && (dm_a[31:2] < 30'(DMEM_WORDS));
  assign pg_in = prog_addr < 32'(IMEM_WORDS);

  assign wr_fifo = dm_we && mm_hit && (mm_sel == 2'd0);
  assign wr_cnt  = dm_we && mm_hit && (mm_sel == 2'd1);
  assign wr_halt = dm_we && mm_hit && (mm_sel == 2'd2);
  assign wr_ovc  = dm_we && mm_hit && (mm_sel == 2'd3);
  assign wr_dm   = dm_we && dm_in;

  assign empty    = (count == '0);
  assign full     = (count == (FW+1)'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  assign push     = wr_fifo;
  assign push_ok  = push && (!full || pop);

  // Storage is never reset, so the head is masked while the FIFO is empty.
  assign tx_data = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_comb begin
    im_rd = 32'h0;
    if (im_in) begin
      im_rd = imem[im_a[IW+1:2]];
    end
  end

  always_comb begin
    mm_rd = 32'h0;
    unique case (mm_sel)
      2'd0: mm_rd = {29'b0, overflow, full, empty};
      2'd1: mm_rd = cycle_cnt;
      2'd2: mm_rd = {31'b0, halt};
      2'd3: mm_rd = 32'(count);
      default: mm_rd = 32'h0;
    endcase
  end

  always_comb begin
    dm_rd = 32'h0;
    unique case (1'b1)
      mm_hit: dm_rd = mm_rd;
      dm_in:  dm_rd = dmem[dm_a[DW+1:2]];
      default: dm_rd = 32'h0;
    endcase
  end

  assign core_in = {dm_rd, im_rd};

  always_ff @(posedge clk) begin
    if (wr_dm) begin
      dmem[dm_a[DW+1:2]] <= dm_wd;
    end
    if (prog_we && pg_in) begin
      imem[prog_addr[IW-1:0]] <= prog_data;
    end
    if (push_ok) begin
      fifo_mem[wr_ptr] <= dm_wd[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + FW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + FW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (FW+1)'(1);
        2'b01:   count <= count - (FW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped push beats a same-cycle clear so no overflow goes unseen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      halt      <= 1'b0;
      cycle_cnt <= 32'h0;
    end else begin
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (wr_ovc) begin
        overflow <= 1'b0;
      end
      if (wr_halt && dm_wd[0]) begin
        halt <= 1'b1;
      end
      if (wr_cnt) begin
        cycle_cnt <= dm_wd;
      end else begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{im_a[1:0], dm_a[1:0], mm_off[31:4], mm_off[1:0]};

endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: directed and random bus traffic checked each
// cycle against a queue/array model of the memory responder.
module tb_core_mem_responder;

  localparam int unsigned IMW  = 1024;
  localparam int unsigned DMW  = 1024;
  localparam int unsigned DEP  = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [96:0] core_out;
  logic [63:0] core_in;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        halt;

  logic [31:0] im_a = '0;
  logic [31:0] dm_a = '0;
  logic [31:0] dm_wd = '0;
  logic        dm_we = 1'b0;

  assign core_out = {dm_we, dm_wd, dm_a, im_a};

  core_mem_responder #(
    .IMEM_WORDS(IMW),
    .DMEM_WORDS(DMW),
    .FIFO_DEPTH(DEP),
    .MMIO_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_out(core_out),
    .core_in(core_in),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .halt(halt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] imem_m [int];
  logic [31:0] dmem_m [int];
  logic [7:0]  q_m [$];
  logic [31:0] cnt_m = '0;
  bit          halt_m = 1'b0;
  bit          ovf_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  function automatic bit exp_im(output logic [31:0] v);
    int unsigned idx = im_a / 4;
    v = '0;
    if (idx >= IMW) return 1'b1;
    if (imem_m.exists(int'(idx))) begin
      v = imem_m[int'(idx)];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_dm(output logic [31:0] v);
    int unsigned idx = dm_a / 4;
    int unsigned n = q_m.size();
    v = '0;
    if (in_mmio(dm_a)) begin
      case ((dm_a - BASE) / 4)
        0: v = 32'(ovf_m) * 4 + 32'(n == DEP) * 2 + 32'(n == 0);
        1: v = cnt_m;
        2: v = 32'(halt_m);
        default: v = 32'(n);
      endcase
      return 1'b1;
    end
    if (idx >= DMW) return 1'b1;
    if (dmem_m.exists(int'(idx))) begin
      v = dmem_m[int'(idx)];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    q_m.delete();
    cnt_m  = '0;
    halt_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  task automatic model_edge();
    int reg_n;
    bit pop;
    if (prog_we && prog_addr < IMW) imem_m[int'(prog_addr)] = prog_data;
    if (dm_we && !in_mmio(dm_a) && dm_a / 4 < DMW)
      dmem_m[int'(dm_a / 4)] = dm_wd;
    if (reset) begin
      model_reset();
      return;
    end
    reg_n = in_mmio(dm_a) ? int'((dm_a - BASE) / 4) : -1;
    pop = (q_m.size() > 0) && tx_ready;
    if (dm_we && reg_n == 3) ovf_m = 1'b0;
    if (pop) void'(q_m.pop_front());
    if (dm_we && reg_n == 0) begin
      if (q_m.size() < DEP) q_m.push_back(dm_wd[7:0]);
      else ovf_m = 1'b1;
    end
    cnt_m = (dm_we && reg_n == 1) ? dm_wd : cnt_m + 32'd1;
    if (dm_we && reg_n == 2 && dm_wd[0]) halt_m = 1'b1;
  endtask

  // One bus cycle: compare against the model, clock, advance the model.
  task automatic cyc();
    logic [31:0] v;
    #1;
    if (exp_im(v)) chk("im_rd", core_in[31:0], v);
    if (exp_dm(v)) chk("dm_rd", core_in[63:32], v);
    chk("tx_valid", 32'(tx_valid), 32'(q_m.size() > 0));
    if (q_m.size() > 0) chk("tx_data", 32'(tx_data), 32'(q_m[0]));
    chk("halt", 32'(halt), 32'(halt_m));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic bus(input logic [31:0] da, input logic [31:0] wd,
                     input logic we);
    dm_a = da;
    dm_wd = wd;
    dm_we = we;
  endtask

  initial begin
    logic [31:0] pgm [3];
    logic [31:0] cexp [3];
    logic [7:0]  b;
    pgm[0] = 32'h00500093;
    pgm[1] = 32'h00A00113;
    pgm[2] = 32'h0;
    cexp[0] = 32'hFFFF_FFFE;
    cexp[1] = 32'hFFFF_FFFF;
    cexp[2] = 32'h0;

    @(negedge clk);
    bus(BASE + 4, 0, 0);
    cyc();
    cyc();
    #1;
    chk("rst_txv", 32'(tx_valid), 0);
    chk("rst_halt", 32'(halt), 0);
    chk("rst_cnt", core_in[63:32], 0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1;
      prog_addr = i;
      prog_data = pgm[i];
      cyc();
    end
    prog_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      im_a = 4 * i;
      #1;
      chk("imem_lit", core_in[31:0], pgm[i]);
      cyc();
    end
    im_a = 4 * IMW;
    #1;
    chk("imem_oob", core_in[31:0], 0);
    cyc();

    bus(32'h10, 32'hDEADBEEF, 1);
    cyc();
    bus(32'h13, 0, 0);
    #1;
    chk("dmem_lit", core_in[63:32], 32'hDEADBEEF);
    cyc();
    bus(32'h0001_0000, 32'h12345678, 1);
    cyc();
    bus(32'h0001_0000, 0, 0);
    #1;
    chk("dmem_oob", core_in[63:32], 0);
    cyc();

    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(BASE, 32'h41 + i, 1);
      cyc();
    end
    bus(BASE, 0, 0);
    #1;
    chk("stat_full", core_in[63:32], 32'b010);
    cyc();
    bus(BASE + 12, 0, 0);
    #1;
    chk("count_8", core_in[63:32], 8);
    cyc();
    bus(BASE, 32'h49, 1);
    cyc();
    bus(BASE, 0, 0);
    #1;
    chk("stat_ovf", core_in[63:32], 32'b110);
    cyc();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_v", 32'(tx_valid), 1);
      chk("drain_d", 32'(tx_data), 32'h41 + i);
      cyc();
    end
    #1;
    chk("drain_end", 32'(tx_valid), 0);
    chk("stat_empty", core_in[63:32], 32'b101);
    cyc();
    bus(BASE + 12, 32'h0, 1);
    cyc();
    bus(BASE, 0, 0);
    #1;
    chk("stat_clr", core_in[63:32], 32'b001);
    cyc();

    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(BASE, 32'h41 + i, 1);
      cyc();
    end
    tx_ready = 1'b1;
    bus(BASE, 32'h5A, 1);
    #1;
    chk("full_pp_head", 32'(tx_data), 32'h41);
    cyc();
    tx_ready = 1'b0;
    bus(BASE + 12, 0, 0);
    #1;
    chk("full_pp_cnt", core_in[63:32], 8);
    cyc();
    bus(BASE, 0, 0);
    #1;
    chk("full_pp_stat", core_in[63:32], 32'b010);
    cyc();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = (i < 7) ? 8'(8'h42 + i) : 8'h5A;
      #1;
      chk("pp_order", 32'(tx_data), 32'(b));
      cyc();
    end
    tx_ready = 1'b0;

    bus(BASE + 4, 32'hFFFF_FFFE, 1);
    cyc();
    bus(BASE + 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("cnt_wrap", core_in[63:32], cexp[i]);
      cyc();
    end
    bus(BASE + 8, 1, 1);
    cyc();
    bus(BASE + 8, 0, 1);
    #1;
    chk("halt_set", 32'(halt), 1);
    cyc();
    bus(BASE + 8, 0, 0);
    #1;
    chk("halt_stick", core_in[63:32], 1);
    cyc();

    bus(32'h10, 32'hCAFEF00D, 1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus(BASE, 32'h60 + i, 1);
      cyc();
    end
    bus(BASE + 4, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mrst_txv", 32'(tx_valid), 0);
    chk("mrst_halt", 32'(halt), 0);
    chk("mrst_cnt", core_in[63:32], 0);
    dm_a = 32'h10;
    #1;
    chk("mrst_dmem", core_in[63:32], 32'hCAFEF00D);
    cyc();
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      int r;
      prog_we = ($urandom_range(0, 7) == 0);
      prog_addr = ($urandom_range(0, 9) == 0) ? 32'(IMW + $urandom_range(0, 5))
                                              : 32'($urandom_range(0, 15));
      prog_data = $urandom;
      im_a = ($urandom_range(0, 9) == 0) ? 32'(4 * IMW + $urandom_range(0, 99))
                                         : 32'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      if (r < 4) dm_a = 32'($urandom_range(0, 63));
      else if (r < 8) dm_a = BASE + 32'($urandom_range(0, 15));
      else if (r == 8) dm_a = 32'h0001_0000 + 32'($urandom_range(0, 63));
      else dm_a = BASE + 32'h10 + 32'($urandom_range(0, 7));
      dm_we = ($urandom_range(0, 9) < 4);
      dm_wd = $urandom;
      tx_ready = $urandom_range(0, 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for the 5-stage core's flat bus: consumes the core's 97-bit output bus and drives its 64-bit input bus.
- Harvard organisation: instruction RAM serves fetch, data RAM serves load/store, and an MMIO window at MMIO_BASE.
- MMIO provides a byte TX FIFO with ready/valid drain, a free-running cycle counter, a sticky halt flag and an overflow flag.
- Sits beside the core in the SoC top level.

Parameters:
IMEM_WORDS, 1024, instruction RAM depth in 32-bit words
DMEM_WORDS, 1024, data RAM depth in 32-bit words
FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)
MMIO_BASE, 32'hFFFF_0000, base byte address of MMIO window (16 bytes)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
core_out  input  97  core bus: [31:0] IM_A, [63:32] DM_A, [95:64] DM_WD, [96] DM_WE
core_in  output  64  core bus: [31:0] IM_RD, [63:32] DM_RD
prog_we  input  1  instruction RAM load strobe
prog_addr  input  32  instruction RAM load word index
prog_data  input  32  instruction RAM load data
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  downstream accepts head byte
halt  output  1  sticky halt flag

Behaviour:
- Address decode uses byte addresses; bits [1:0] are ignored, so word index = A[31:2].
- Reads are combinational and same-cycle. The core registers IM_RD and DM_RD in its pipe stages.
- IM_RD = imem[IM_A>>2] when the index is < IMEM_WORDS, else 32'h0.
- DM_RD decode:
  - DM_A in [MMIO_BASE, MMIO_BASE+15]: MMIO read.
  - else index < DMEM_WORDS: dmem[index].
  - else 32'h0.
- Data writes happen on posedge clk when DM_WE=1.
  - MMIO range: MMIO write.
  - In-range DM address: dmem[index] <= DM_WD.
  - Out-of-range: dropped silently.
- prog_we writes imem[prog_addr] <= prog_data on posedge. Out-of-range is dropped. Allowed at any time.
- RAM contents are not affected by reset and have no defined power-up value.
- MMIO map (offsets from MMIO_BASE):
  - +0x0 write: push DM_WD[7:0] into FIFO.
  - +0x0 read: {29'b0, overflow, full, empty}.
  - +0x4 read: cycle counter. Write: counter loads DM_WD.
  - +0x8 write: if DM_WD[0]=1, halt is set (sticky; only reset clears). Read: {31'b0, halt}.
  - +0xC write: any value clears overflow. Read: {28'b0, count} with count 0..FIFO_DEPTH, zero-extended.
- Cycle counter:
  - 32-bit, increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0.
  - A write that cycle loads DM_WD instead of incrementing. The next cycle reads DM_WD, then +1 after that.
- TX FIFO:
  - tx_valid = !empty; tx_data = head byte, held stable while tx_valid && !tx_ready.
  - Pop when tx_valid && tx_ready.
  - Push accepted when !full, or when full and a pop occurs the same cycle (count unchanged).
  - Push when full with no pop: byte dropped, overflow set (sticky). FIFO contents unchanged.
  - Push into empty FIFO: tx_valid rises the next cycle. No combinational bypass.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
  - Overflow clear (+0xC write) and an overflowing push in the same cycle: overflow ends set.
  - Pointers wrap modulo FIFO_DEPTH. A separate count register or an extra pointer bit distinguishes full from empty.
- Reset (asynchronous, any time including mid-transfer):
  - FIFO pointers/count = 0, so tx_valid=0 and buffered bytes are lost.
  - tx_data = 8'h0, counter = 0, halt = 0, overflow = 0.
  - core_in still reflects combinational RAM reads.
- halt is informational only. The block keeps servicing the bus after halt is set.

Test Plan:
- Load imem[0..2] = 32'h00500093, 32'h00A00113, 32'h0 via the prog port; drive IM_A=0,4,8 -> IM_RD = 00500093, 00A00113, 0. IM_A=4*IMEM_WORDS -> 0.
- Store DM_A=32'h10, DM_WD=32'hDEADBEEF, DM_WE=1 for one cycle; then read DM_A=32'h13 -> DM_RD=DEADBEEF. Store to out-of-range DM_A=32'h0001_0000 -> no RAM word changes, read returns 0.
- With tx_ready=0, push 0x41..0x48 (8 bytes):
  - status reads 3'b010 and +0xC reads 8.
  - A 9th push of 0x49 sets overflow, status reads 3'b110.
  - Raise tx_ready: bytes appear 0x41..0x48 in order, one per cycle, then tx_valid=0 and status reads 3'b101.
  - Write +0xC -> status reads 3'b001.
- FIFO full, tx_ready=1, push 0x5A in the same cycle -> 0x41 popped, 0x5A accepted, count stays 8, overflow stays 0. 0x5A exits last.
- Write +0x4 = 32'hFFFF_FFFE -> reads FFFFFFFE, FFFFFFFF, 00000000 on successive cycles. Write +0x8 = 1 -> halt=1. Write +0x8 = 0 -> halt stays 1.
- Push 3 bytes with tx_ready=0, then assert reset mid-cycle -> tx_valid=0, counter=0, halt=0 immediately; dmem[4] written before reset still reads back its value.
